// File: rtl/me_iddmm_pkg.sv
// Shared constants for the Montgomery multiplier arbiter.
// Default sizes, FSM encodings and a counter-width helper.
package me_iddmm_pkg;

    localparam int K_DEF         = 128;
    localparam int N_DEF         = 32;
    localparam int NREQ_DEF      = 4;
    localparam int START_GAP_DEF = 10;
    localparam int TIMEOUT_DEF   = 65535;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_UNLOAD = 3'd5;

    function automatic int cnt_w(input int v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/me_iddmm_arbiter_if.sv
// Engine-side bus between the arbiter and the shared multiplier.
// master: arbiter (start, x/y beats); slave: engine (result beats).
interface me_iddmm_arbiter_if
    import me_iddmm_pkg::*;
#(
    parameter int K = K_DEF
);
    logic         me_start;
    logic [K-1:0] me_x;
    logic [K-1:0] me_y;
    logic         me_x_valid;
    logic         me_y_valid;
    logic [K-1:0] me_result;
    logic         me_valid;

    modport master (
        output me_start, me_x, me_y,
        output me_x_valid, me_y_valid,
        input  me_result, me_valid
    );

    modport slave (
        input  me_start, me_x, me_y,
        input  me_x_valid, me_y_valid,
        output me_result, me_valid
    );
endinterface

// File: rtl/me_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr.
// Ports: req, ptr in; onehot, idx out (zero when no req).
module me_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IW = $clog2(NREQ);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end
endmodule

// File: rtl/me_iddmm_arbiter.sv
// Shares one Montgomery engine among NREQ requesters, round-robin.
// Ports: req/gnt/done/err per requester, op_* operand pull, res_* result push, me engine bus.
module me_iddmm_arbiter
    import me_iddmm_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int N         = N_DEF,
    parameter int NREQ      = NREQ_DEF,
    parameter int START_GAP = START_GAP_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         op_rd,
    output logic [$clog2(N)-1:0]    op_idx,
    input  logic [NREQ*K-1:0]       op_x,
    input  logic [NREQ*K-1:0]       op_y,
    output logic [NREQ-1:0]         res_valid,
    output logic [K-1:0]            res_data,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    me_iddmm_arbiter_if.master      me
);
    localparam int IW = $clog2(NREQ);
    localparam int XW = $clog2(N);
    localparam int BW = cnt_w(N);
    localparam int TW = cnt_w(TIMEOUT);

    logic [2:0]      state;
    logic [IW-1:0]   g;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   nxt;
    logic [TW-1:0]   cnt;
    logic [BW-1:0]   bcnt;
    logic            rd_d1;
    logic            last_d1;
    logic            zpend;
    logic            acc;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;

    me_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (rr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign nxt = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;

    // Results pass straight through; only accepted while a job waits on them.
    assign acc       = me.me_valid && (state == S_WAIT || state == S_UNLOAD);
    assign res_valid = acc ? gnt : '0;
    assign res_data  = acc ? me.me_result : '0;

    assign me.me_y_valid = me.me_x_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            gnt         <= '0;
            g           <= '0;
            rr          <= '0;
            cnt         <= '0;
            bcnt        <= '0;
            op_rd       <= '0;
            op_idx      <= '0;
            done        <= '0;
            err         <= '0;
            me.me_start <= 1'b0;
        end else begin
            done        <= '0;
            err         <= '0;
            me.me_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt   <= pick_oh;
                        g     <= pick_idx;
                        state <= S_START;
                    end
                end
                S_START: begin
                    me.me_start <= 1'b1;
                    cnt         <= '0;
                    state       <= S_GAP;
                end
                S_GAP: begin
                    cnt <= cnt + 1'b1;
                    // Read issued two cycles ahead: requester latency + forward register.
                    if (cnt == TW'(START_GAP - 2)) begin
                        op_rd  <= gnt;
                        op_idx <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (|op_rd) begin
                        if (op_idx == XW'(N - 1)) begin
                            op_rd  <= '0;
                            op_idx <= '0;
                        end else begin
                            op_idx <= op_idx + 1'b1;
                        end
                    end
                    if (zpend) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (me.me_valid) begin
                        bcnt  <= BW'(1);
                        state <= S_UNLOAD;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        err   <= gnt;
                        gnt   <= '0;
                        rr    <= nxt;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (me.me_valid) begin
                        if (bcnt == BW'(N - 1)) begin
                            done  <= gnt;
                            gnt   <= '0;
                            rr    <= nxt;
                            state <= S_IDLE;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand forward: N data beats, then one zero beat flagged by zpend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d1         <= 1'b0;
            last_d1       <= 1'b0;
            zpend         <= 1'b0;
            me.me_x       <= '0;
            me.me_y       <= '0;
            me.me_x_valid <= 1'b0;
        end else begin
            rd_d1   <= |op_rd;
            last_d1 <= (|op_rd) && (op_idx == XW'(N - 1));
            zpend   <= last_d1;
            if (rd_d1) begin
                me.me_x       <= op_x[g*K +: K];
                me.me_y       <= op_y[g*K +: K];
                me.me_x_valid <= 1'b1;
            end else begin
                me.me_x       <= '0;
                me.me_y       <= '0;
                me.me_x_valid <= zpend;
            end
        end
    end
endmodule

// File: tb/tb_me_iddmm_arbiter.sv
// Bench for me_iddmm_arbiter with a behavioural engine stub.
// Stub result word i = x_i + y_i; scoreboard recomputes it from operand formulas.
module tb_me_iddmm_arbiter;
    localparam int K  = 128;
    localparam int N  = 32;
    localparam int NR = 4;
    localparam int SG = 10;
    localparam int TO = 100;

    typedef struct {
        logic [3:0] req;
        logic [3:0] late;
        bit         hang;
        bit         drop;
        bit         early;
        int         njobs;
        logic [7:0] ord;
    } vec_t;

    typedef struct {
        int who;
        int beats;
        int bad;
        int lat;
        bit is_err;
        int elat;
    } job_t;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   op_rd;
    logic [4:0]      op_idx;
    logic [NR*K-1:0] op_x;
    logic [NR*K-1:0] op_y;
    logic [NR-1:0]   res_valid;
    logic [K-1:0]    res_data;
    logic [NR-1:0]   done;
    logic [NR-1:0]   err;

    me_iddmm_arbiter_if #(.K(K)) eng ();

    me_iddmm_arbiter #(
        .K(K), .N(N), .NREQ(NR), .START_GAP(SG), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .op_rd(op_rd), .op_idx(op_idx), .op_x(op_x), .op_y(op_y),
        .res_valid(res_valid), .res_data(res_data),
        .done(done), .err(err), .me(eng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nbad = 0;
    logic [31:0] seed = 32'h1234_5678;
    bit          hang = 0;
    bit          drop = 0;
    bit          stray = 0;

    function automatic logic [K-1:0] xw(input int i, input int j);
        return {seed, 32'(i * 1000 + j), 32'hDEAD0000 | 32'(j),
                seed ^ 32'(j << 3)};
    endfunction

    function automatic logic [K-1:0] yw(input int i, input int j);
        logic [K-1:0] v;
        v = xw(i, j);
        return {v[63:0], v[127:64]} ^ {4{32'h5A5A1234 + 32'(i)}};
    endfunction

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] o4(input int a, b, c, d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    function automatic logic [11:0] outs_nz();
        return {|gnt, |op_rd, |op_idx, |res_valid, |res_data, |done,
                |err, eng.me_start, |eng.me_x, |eng.me_y,
                eng.me_x_valid, eng.me_y_valid};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] expv);
        nvec++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Requesters: operand word valid one cycle after op_rd.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (op_rd[i]) begin
                op_x[i*K +: K] <= xw(i, int'(op_idx));
                op_y[i*K +: K] <= yw(i, int'(op_idx));
            end
        end
    end

    // Engine stub.
    logic [K-1:0] ex [N];
    logic [K-1:0] ey [N];
    int ebeats = 0;
    int eout = -1;
    int edly = 0;
    int dcnt = 0;
    int zbad = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ebeats = 0;
            eout = -1;
            edly = 0;
            dcnt = 0;
            eng.me_valid  <= 1'b0;
            eng.me_result <= '0;
        end else begin
            eng.me_valid  <= 1'b0;
            eng.me_result <= '0;
            if (eng.me_start) begin
                ebeats = 0;
                eout = -1;
                dcnt = 0;
            end
            if (eng.me_x_valid) begin
                if (ebeats < N) begin
                    ex[ebeats] = eng.me_x;
                    ey[ebeats] = eng.me_y;
                end else if (ebeats == N) begin
                    if (eng.me_x != 0 || eng.me_y != 0) zbad++;
                end else begin
                    zbad++;
                end
                ebeats++;
                if (ebeats == N + 1 && !hang) begin
                    eout = 0;
                    edly = 3;
                end
            end else if (eout >= 0 && eout < N) begin
                if (edly > 0) edly--;
                else if (drop && eout == 10 && dcnt < 3) dcnt++;
                else begin
                    eng.me_valid  <= 1'b1;
                    eng.me_result <= ex[eout] + ey[eout];
                    eout++;
                end
            end
            if (stray) begin
                eng.me_valid  <= 1'b1;
                eng.me_result <= '1;
            end
        end
    end

    // Scoreboard / monitor.
    job_t jobs[$];
    int cyc = 0;
    int rb = 0;
    int jbad = 0;
    int lat = -1;
    int st_cyc = 0;
    int xv_last = 0;
    int multihot = 0;
    int ybad = 0;
    bit seen_xv = 0;
    logic [NR-1:0] gprev = '0;

    always @(negedge clk) begin
        cyc++;
        if (gnt != 0 && !$onehot(gnt)) multihot++;
        if (eng.me_y_valid !== eng.me_x_valid) ybad++;
        if (gnt != 0 && gprev == 0) begin
            rb = 0;
            jbad = 0;
            lat = -1;
            seen_xv = 0;
        end
        gprev = gnt;
        if (eng.me_start) st_cyc = cyc;
        if (eng.me_x_valid) begin
            if (!seen_xv) begin
                lat = cyc - st_cyc;
                seen_xv = 1;
            end
            xv_last = cyc;
        end
        if (res_valid != 0) begin
            if (res_valid !== gnt) jbad++;
            else if (res_data !== xw(oh2i(gnt), rb) + yw(oh2i(gnt), rb))
                jbad++;
            rb++;
        end
        if (done != 0)
            jobs.push_back('{oh2i(done), rb, jbad, lat, 1'b0, 0});
        if (err != 0)
            jobs.push_back('{oh2i(err), rb, jbad, lat, 1'b1,
                             cyc - xv_last});
    end

    task automatic run_vec(input vec_t t);
        int   jstart;
        int   budget;
        int   n;
        int   mh0;
        int   yb0;
        int   zb0;
        bit   lated;
        job_t j;
        jstart = jobs.size();
        mh0 = multihot;
        yb0 = ybad;
        zb0 = zbad;
        budget = 0;
        lated = 0;
        req = t.req;
        while ((req != 0 || jobs.size() - jstart < t.njobs)
               && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (gnt != 0 && !lated) begin
                lated = 1;
                req = req | t.late;
                if (t.early) req = req & ~gnt;
            end
            req = req & ~(done | err);
        end
        chk("vec_timeout", budget >= 4000, 0);
        chk("njobs", jobs.size() - jstart, t.njobs);
        n = jobs.size() - jstart;
        if (n > t.njobs) n = t.njobs;
        for (int k = 0; k < n; k++) begin
            j = jobs[jstart + k];
            chk("grant_order", j.who, t.ord[2*k +: 2]);
            chk("err_flag", j.is_err, t.hang);
            chk("res_beats", j.beats, t.hang ? 0 : N);
            chk("res_data", j.bad, 0);
            chk("xvalid_lat", j.lat, SG + 1);
            if (t.hang) chk("timeout_cyc", j.elat, TO);
        end
        chk("gnt_onehot", multihot - mh0, 0);
        chk("y_valid_eq", ybad - yb0, 0);
        chk("zero_beat", zbad - zb0, 0);
        req = '0;
    endtask

    vec_t tab[8];
    vec_t vr;
    int   bud;
    bit   found;

    initial begin
        tab[0] = '{4'b1111, 4'b0000, 0, 0, 0, 4, o4(0, 1, 2, 3)};
        tab[1] = '{4'b0001, 4'b0000, 0, 0, 0, 1, o4(0, 0, 0, 0)};
        tab[2] = '{4'b0100, 4'b0000, 1, 0, 0, 1, o4(2, 0, 0, 0)};
        tab[3] = '{4'b0010, 4'b0000, 0, 1, 0, 1, o4(1, 0, 0, 0)};
        tab[4] = '{4'b1001, 4'b0000, 0, 0, 0, 2, o4(3, 0, 0, 0)};
        tab[5] = '{4'b0100, 4'b0001, 0, 0, 0, 2, o4(2, 0, 0, 0)};
        tab[6] = '{4'b0100, 4'b1001, 0, 0, 0, 3, o4(2, 3, 0, 0)};
        tab[7] = '{4'b0010, 4'b0000, 0, 0, 1, 1, o4(1, 0, 0, 0)};
        vr     = '{4'b0001, 4'b0000, 0, 0, 0, 1, o4(0, 0, 0, 0)};

        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs_nz(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs_nz(), 0);

        stray = 1;
        @(negedge clk);
        stray = 0;
        chk("stray_rv", res_valid, 0);
        chk("stray_data", res_data, 0);
        @(negedge clk);
        chk("stray_gnt", gnt, 0);

        for (int v = 0; v < 8; v++) begin
            hang = tab[v].hang;
            drop = tab[v].drop;
            seed = seed * 32'd1103515245 + 32'd12345;
            run_vec(tab[v]);
        end
        hang = 0;
        drop = 0;

        req = 4'b0001;
        found = 0;
        bud = 0;
        while (!found && bud < 300) begin
            @(negedge clk);
            bud++;
            found = op_rd[0] && op_idx == 5'd15;
        end
        chk("reach_beat15", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_midjob", outs_nz(), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vr);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
